// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue and the source stage.
// Queue geometry, renamed-uop/entry layouts, and the issue payload shared with sreg.
package alu_issue_queue_pkg;
   localparam int IQ_DEPTH   = 16;
   localparam int IQ_DISP_W  = 2;
   localparam int IQ_ISSUE_W = 4;
   localparam int IQ_WAKE_W  = 4;
   localparam int IQ_IDX_W   = $clog2(IQ_DEPTH);
   localparam int IQ_OCC_W   = $clog2(IQ_DEPTH + 1);

   typedef logic [5:0] preg_t;
   typedef logic [4:0] areg_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [7:0]  ctl;
      preg_t       dst;
      preg_t       psrc1;
      preg_t       psrc2;
      areg_t       src1;
      areg_t       src2;
      logic        forward_en1;
      logic        forward_en2;
   } alu_issue_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [7:0]  ctl;
      preg_t       dst;
      preg_t       psrc1;
      preg_t       psrc2;
      areg_t       src1;
      areg_t       src2;
      logic        forward_en1;
      logic        forward_en2;
   } iq_uop_t;

   typedef struct packed {
      logic    valid;
      logic    rdy1;
      logic    rdy2;
      iq_uop_t uop;
   } iq_entry_t;

   function automatic alu_issue_t to_alu_issue(input iq_uop_t u);
      alu_issue_t a;
      a.pc          = u.pc;
      a.imm         = u.imm;
      a.ctl         = u.ctl;
      a.dst         = u.dst;
      a.psrc1       = u.psrc1;
      a.psrc2       = u.psrc2;
      a.src1        = u.src1;
      a.src2        = u.src2;
      a.forward_en1 = u.forward_en1;
      a.forward_en2 = u.forward_en2;
      return a;
   endfunction
endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch / wakeup / issue bundle of the ALU issue queue.
// master = rename/dispatch + sreg side, slave = the queue itself.
interface alu_issue_queue_if;
   import alu_issue_queue_pkg::*;

   logic                             flush;
   logic                             stall;
   logic    [IQ_DISP_W-1:0]          disp_valid;
   iq_uop_t [IQ_DISP_W-1:0]          disp_uop;
   logic                             disp_ready;
   logic    [IQ_WAKE_W-1:0]          wake_valid;
   preg_t   [IQ_WAKE_W-1:0]          wake_tag;
   logic    [IQ_ISSUE_W-1:0]         issue_valid;
   alu_issue_t [IQ_ISSUE_W-1:0]      issue_uop;
   logic    [IQ_OCC_W-1:0]           occupancy;

   modport master (
      output flush, stall, disp_valid, disp_uop, wake_valid, wake_tag,
      input  disp_ready, issue_valid, issue_uop, occupancy
   );

   modport slave (
      input  flush, stall, disp_valid, disp_uop, wake_valid, wake_tag,
      output disp_ready, issue_valid, issue_uop, occupancy
   );
endinterface

// File: rtl/alu_issue_queue_select.sv
// Pick-first-N-of-M priority encoder: lowest set request bits go to outputs 0..N-1 in order.
// Purely combinational; outputs beyond the number of requests are zero.
module iq_select #(
   parameter int M  = 16,
   parameter int N  = 4,
   parameter int IW = (M > 1) ? $clog2(M) : 1
) (
   input  logic [M-1:0]         i_req,
   output logic [N-1:0]         o_vld,
   output logic [N-1:0][IW-1:0] o_idx
);
   always_comb begin
      int cnt;
      cnt   = 0;
      o_vld = '0;
      o_idx = '0;
      for (int i = 0; i < M; i++) begin
         if (i_req[i] && cnt < N) begin
            for (int n = 0; n < N; n++) begin
               if (n == cnt) begin
                  o_vld[n] = 1'b1;
                  o_idx[n] = IW'(i);
               end
            end
            cnt = cnt + 1;
         end
      end
   end
endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds renamed uops until both sources are ready, issues up to 4/cycle.
// Issue 1 cycle after ready (0 with ALU_IQ_WAKE_BYPASS_EN); stall holds entries, dispatch all-or-nothing.
module alu_issue_queue
   import alu_issue_queue_pkg::*;
(
   input logic              clk,
   input logic              resetn,
   alu_issue_queue_if.slave iq
);
   iq_entry_t                          r_ent [IQ_DEPTH];
   logic      [IQ_OCC_W-1:0]           r_occ;

   logic      [IQ_DEPTH-1:0]           w_valid, w_m1, w_m2, w_cand, w_freed;
   logic      [IQ_DISP_W-1:0]          w_dm1, w_dm2, w_lane_we;
   logic      [IQ_DISP_W-1:0][IQ_IDX_W-1:0]  w_lane_slot;
   iq_entry_t [IQ_DISP_W-1:0]          w_new;
   logic      [IQ_DISP_W-1:0]          w_free_vld;
   logic      [IQ_DISP_W-1:0][IQ_IDX_W-1:0]  w_free_idx;
   logic      [IQ_ISSUE_W-1:0]         w_pick_vld;
   logic      [IQ_ISSUE_W-1:0][IQ_IDX_W-1:0] w_pick_idx;
   logic      [IQ_OCC_W-1:0]           w_n_acc, w_n_iss;
   logic                               w_disp_rdy, w_iss_en;

   assign w_disp_rdy    = !iq.flush && ((IQ_DEPTH - int'(r_occ)) >= IQ_DISP_W);
   assign w_iss_en      = !iq.flush && !iq.stall;
   assign iq.disp_ready = w_disp_rdy;
   assign iq.occupancy  = r_occ;

   // Tag match against the broadcast ports, for resident entries and incoming lanes.
   always_comb begin
      for (int s = 0; s < IQ_DEPTH; s++) begin
         w_m1[s]    = 1'b0;
         w_m2[s]    = 1'b0;
         w_valid[s] = r_ent[s].valid;
         for (int k = 0; k < IQ_WAKE_W; k++) begin
            if (iq.wake_valid[k] && iq.wake_tag[k] == r_ent[s].uop.psrc1) w_m1[s] = 1'b1;
            if (iq.wake_valid[k] && iq.wake_tag[k] == r_ent[s].uop.psrc2) w_m2[s] = 1'b1;
         end
`ifdef ALU_IQ_WAKE_BYPASS_EN
         w_cand[s] = r_ent[s].valid && (r_ent[s].rdy1 || w_m1[s]) && (r_ent[s].rdy2 || w_m2[s]);
`else
         w_cand[s] = r_ent[s].valid && r_ent[s].rdy1 && r_ent[s].rdy2;
`endif
      end
      for (int l = 0; l < IQ_DISP_W; l++) begin
         w_dm1[l] = 1'b0;
         w_dm2[l] = 1'b0;
         for (int k = 0; k < IQ_WAKE_W; k++) begin
            if (iq.wake_valid[k] && iq.wake_tag[k] == iq.disp_uop[l].psrc1) w_dm1[l] = 1'b1;
            if (iq.wake_valid[k] && iq.wake_tag[k] == iq.disp_uop[l].psrc2) w_dm2[l] = 1'b1;
         end
         w_new[l].valid = 1'b1;
         w_new[l].rdy1  = (iq.disp_uop[l].psrc1 == '0) || !iq.disp_uop[l].forward_en1 || w_dm1[l];
         w_new[l].rdy2  = (iq.disp_uop[l].psrc2 == '0) || !iq.disp_uop[l].forward_en2 || w_dm2[l];
         w_new[l].uop   = iq.disp_uop[l];
      end
   end

   iq_select #(.M(IQ_DEPTH), .N(IQ_DISP_W)) u_alloc (
      .i_req (~w_valid),
      .o_vld (w_free_vld),
      .o_idx (w_free_idx)
   );

   iq_select #(.M(IQ_DEPTH), .N(IQ_ISSUE_W)) u_pick (
      .i_req (w_cand),
      .o_vld (w_pick_vld),
      .o_idx (w_pick_idx)
   );

   // Valid lanes are packed onto the free slots in order, so lane 0 always gets the lowest.
   always_comb begin
      int c;
      c       = 0;
      w_n_acc = '0;
      w_n_iss = '0;
      w_freed = '0;
      for (int l = 0; l < IQ_DISP_W; l++) begin
         w_lane_slot[l] = '0;
         w_lane_we[l]   = 1'b0;
         for (int n = 0; n < IQ_DISP_W; n++) begin
            if (n == c) begin
               w_lane_slot[l] = w_free_idx[n];
               w_lane_we[l]   = w_free_vld[n] && w_disp_rdy && iq.disp_valid[l];
            end
         end
         if (iq.disp_valid[l]) c = c + 1;
         w_n_acc = w_n_acc + IQ_OCC_W'(w_lane_we[l]);
      end
      for (int p = 0; p < IQ_ISSUE_W; p++) begin
         iq.issue_valid[p] = w_pick_vld[p] && w_iss_en;
         iq.issue_uop[p]   = '0;
         if (iq.issue_valid[p]) begin
            iq.issue_uop[p]         = to_alu_issue(r_ent[w_pick_idx[p]].uop);
            w_freed[w_pick_idx[p]]  = 1'b1;
         end
         w_n_iss = w_n_iss + IQ_OCC_W'(iq.issue_valid[p]);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < IQ_DEPTH; s++) r_ent[s] <= '0;
         r_occ <= '0;
      end else if (iq.flush) begin
         for (int s = 0; s < IQ_DEPTH; s++) begin
            r_ent[s].valid <= 1'b0;
            r_ent[s].rdy1  <= 1'b0;
            r_ent[s].rdy2  <= 1'b0;
         end
         r_occ <= '0;
      end else begin
         for (int s = 0; s < IQ_DEPTH; s++) begin
            if (w_freed[s]) begin
               r_ent[s].valid <= 1'b0;
               r_ent[s].rdy1  <= 1'b0;
               r_ent[s].rdy2  <= 1'b0;
            end else if (r_ent[s].valid) begin
               if (w_m1[s]) r_ent[s].rdy1 <= 1'b1;
               if (w_m2[s]) r_ent[s].rdy2 <= 1'b1;
            end
         end
         // Target slots were free at cycle start, so they never collide with the updates above.
         for (int l = 0; l < IQ_DISP_W; l++) begin
            if (w_lane_we[l]) r_ent[w_lane_slot[l]] <= w_new[l];
         end
         r_occ <= r_occ + w_n_acc - w_n_iss;
      end
   end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, dispatch/issue, wakeup, full, stall, flush, async reset.
// Inputs change 1ns after posedge; outputs are compared on the negedge.
module tb_alu_issue_queue;
   import alu_issue_queue_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   alu_issue_queue_if iq ();

   alu_issue_queue u_dut (
      .clk    (clk),
      .resetn (resetn),
      .iq     (iq)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic iq_uop_t mk(input preg_t p1, input preg_t p2, input logic fe1,
                                  input logic fe2, input logic [31:0] pc);
      iq_uop_t u;
      u             = '0;
      u.psrc1       = p1;
      u.psrc2       = p2;
      u.forward_en1 = fe1;
      u.forward_en2 = fe2;
      u.pc          = pc;
      u.imm         = pc ^ 32'h0000_00FF;
      u.dst         = 6'd33;
      return u;
   endfunction

   task automatic idle();
      iq.flush      = 1'b0;
      iq.stall      = 1'b0;
      iq.disp_valid = '0;
      iq.disp_uop   = '0;
      iq.wake_valid = '0;
      iq.wake_tag   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [31:0] iv();
      return 32'(iq.issue_valid);
   endfunction

   function automatic logic [31:0] occ();
      return 32'(iq.occupancy);
   endfunction

   initial begin
      resetn = 1'b1;
      idle();
      #2 resetn = 1'b0;
      #1;
      chk("rst_occ", occ(), 0);
      chk("rst_iv", iv(), 0);
      chk("rst_drdy", 32'(iq.disp_ready), 1);
      tick();
      tick();
      resetn = 1'b1;

      // two ready uops issue next cycle on pipes 0/1 in slot order
      iq.disp_valid  = 2'b11;
      iq.disp_uop[0] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h100);
      iq.disp_uop[1] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h104);
      mid();
      chk("t1_iv_write", iv(), 0);
      chk("t1_drdy", 32'(iq.disp_ready), 1);
      tick(); idle(); mid();
      chk("t1_occ2", occ(), 2);
      chk("t1_iv", iv(), 32'h3);
      chk("t1_pc0", iq.issue_uop[0].pc, 32'h100);
      chk("t1_pc1", iq.issue_uop[1].pc, 32'h104);
      chk("t1_imm0", iq.issue_uop[0].imm, 32'h1FF);
      chk("t1_pc2_zero", iq.issue_uop[2].pc, 0);
      tick(); mid();
      chk("t1_occ0", occ(), 0);
      chk("t1_iv_empty", iv(), 0);

      // uop waiting on preg 7, woken through port 2
      tick();
      iq.disp_valid  = 2'b10;
      iq.disp_uop[1] = mk(6'd7, 6'd0, 1'b1, 1'b1, 32'h200);
      mid();
      tick(); idle(); mid();
      chk("t2_wait_iv", iv(), 0);
      chk("t2_wait_occ", occ(), 1);
      tick();
      iq.wake_valid  = 4'b0100;
      iq.wake_tag[2] = 6'd7;
      mid();
`ifdef ALU_IQ_WAKE_BYPASS_EN
      chk("t2_iv_wake", iv(), 1);
      chk("t2_pc_wake", iq.issue_uop[0].pc, 32'h200);
      tick(); idle(); mid();
      chk("t2_iv_after", iv(), 0);
      chk("t2_occ_after", occ(), 0);
`else
      chk("t2_iv_wake", iv(), 0);
      tick(); idle(); mid();
      chk("t2_iv_after", iv(), 1);
      chk("t2_pc_after", iq.issue_uop[0].pc, 32'h200);
      chk("t2_occ_after", occ(), 1);
`endif
      tick(); mid();
      chk("t2_occ_end", occ(), 0);

      // fill: 14 waiting on preg 9, then one ready uop -> 15 entries
      for (int c = 0; c < 7; c++) begin
         tick(); idle();
         iq.disp_valid  = 2'b11;
         iq.disp_uop[0] = mk(6'd9, 6'd0, 1'b1, 1'b1, 32'h300 + 32'(8 * c));
         iq.disp_uop[1] = mk(6'd9, 6'd0, 1'b1, 1'b1, 32'h304 + 32'(8 * c));
         mid();
         chk("t3_fill_drdy", 32'(iq.disp_ready), 1);
      end
      tick(); idle();
      iq.disp_valid  = 2'b01;
      iq.disp_uop[0] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h3F0);
      mid();
      chk("t3_occ14", occ(), 14);
      chk("t3_drdy14", 32'(iq.disp_ready), 1);
      tick(); idle();
      iq.disp_valid  = 2'b01;
      iq.disp_uop[0] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h3F4);
      mid();
      chk("t3_occ15", occ(), 15);
      chk("t3_drdy15", 32'(iq.disp_ready), 0);
      chk("t3_iv15", iv(), 1);
      chk("t3_pc15", iq.issue_uop[0].pc, 32'h3F0);
      tick(); idle(); mid();
      chk("t3_occ_back14", occ(), 14);
      chk("t3_drdy_back", 32'(iq.disp_ready), 1);
      chk("t3_iv_none", iv(), 0);
      tick();
      iq.flush = 1'b1;
      mid();
      chk("t3_flush_drdy", 32'(iq.disp_ready), 0);
      tick(); idle(); mid();
      chk("t3_flush_occ", occ(), 0);

      // six ready entries held by stall, then drained 4 + 2
      for (int c = 0; c < 3; c++) begin
         tick(); idle();
         iq.stall       = 1'b1;
         iq.disp_valid  = 2'b11;
         iq.disp_uop[0] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h400 + 32'(8 * c));
         iq.disp_uop[1] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h404 + 32'(8 * c));
         mid();
         chk("t4_fill_iv", iv(), 0);
      end
      for (int c = 0; c < 3; c++) begin
         tick(); idle();
         iq.stall = 1'b1;
         mid();
         chk("t4_stall_iv", iv(), 0);
         chk("t4_stall_occ", occ(), 6);
      end
      tick(); idle(); mid();
      chk("t4_rel_iv", iv(), 32'hF);
      chk("t4_rel_occ", occ(), 6);
      chk("t4_rel_pc0", iq.issue_uop[0].pc, 32'h400);
      chk("t4_rel_pc3", iq.issue_uop[3].pc, 32'h40C);
      tick(); mid();
      chk("t4_tail_iv", iv(), 32'h3);
      chk("t4_tail_occ", occ(), 2);
      chk("t4_tail_pc0", iq.issue_uop[0].pc, 32'h410);
      chk("t4_tail_pc1", iq.issue_uop[1].pc, 32'h414);
      tick(); mid();
      chk("t4_end_occ", occ(), 0);

      // flush coincident with dispatch and wakeup
      tick();
      iq.disp_valid  = 2'b11;
      iq.disp_uop[0] = mk(6'd12, 6'd0, 1'b1, 1'b1, 32'h500);
      iq.disp_uop[1] = mk(6'd12, 6'd0, 1'b1, 1'b1, 32'h504);
      mid();
      tick(); idle();
      iq.flush       = 1'b1;
      iq.disp_valid  = 2'b11;
      iq.disp_uop[0] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h510);
      iq.disp_uop[1] = mk(6'd0, 6'd0, 1'b1, 1'b1, 32'h514);
      iq.wake_valid  = 4'b0001;
      iq.wake_tag[0] = 6'd12;
      mid();
      chk("t5_flush_iv", iv(), 0);
      chk("t5_flush_drdy", 32'(iq.disp_ready), 0);
      chk("t5_pre_occ", occ(), 2);
      tick(); idle(); mid();
      chk("t5_post_occ", occ(), 0);
      chk("t5_post_iv", iv(), 0);
      tick(); mid();
      chk("t5_post2_occ", occ(), 0);
      chk("t5_post2_iv", iv(), 0);

      // same-cycle wake at dispatch, plus a forward_en=0 source
      tick();
      iq.disp_valid  = 2'b11;
      iq.disp_uop[0] = mk(6'd0, 6'd20, 1'b1, 1'b1, 32'h600);
      iq.disp_uop[1] = mk(6'd30, 6'd25, 1'b0, 1'b0, 32'h604);
      iq.wake_valid  = 4'b0010;
      iq.wake_tag[1] = 6'd20;
      mid();
      chk("t6_iv_write", iv(), 0);
      tick(); idle(); mid();
      chk("t6_iv", iv(), 32'h3);
      chk("t6_pc0", iq.issue_uop[0].pc, 32'h600);
      chk("t6_pc1", iq.issue_uop[1].pc, 32'h604);
      chk("t6_psrc2", 32'(iq.issue_uop[0].psrc2), 20);
      tick(); mid();
      chk("t6_occ_end", occ(), 0);

      // asynchronous reset while entries are resident
      tick();
      iq.disp_valid  = 2'b11;
      iq.disp_uop[0] = mk(6'd40, 6'd0, 1'b1, 1'b1, 32'h700);
      iq.disp_uop[1] = mk(6'd40, 6'd0, 1'b1, 1'b1, 32'h704);
      tick(); idle(); mid();
      chk("t7_pre_occ", occ(), 2);
      #1 resetn = 1'b0;
      #1;
      chk("t7_rst_occ", occ(), 0);
      chk("t7_rst_drdy", 32'(iq.disp_ready), 1);
      tick();
      resetn = 1'b1;
      iq.wake_valid  = 4'b0001;
      iq.wake_tag[0] = 6'd40;
      mid();
      chk("t7_wake_iv", iv(), 0);
      tick(); idle(); mid();
      chk("t7_after_iv", iv(), 0);
      chk("t7_after_occ", occ(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
